// File: rtl/interp_pkg.sv
// Shared types and defaults for the stage-2 interpolation sequencer.
package interp_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int L_DEFAULT  = 4;
  localparam int PHASE_W    = $clog2(L_DEFAULT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; DEPTH must be a power of two.
module sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push against a full FIFO is dropped, never written through.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/interp_x4_seq.sv
// Stage-2 interpolation sequencer: buffers low-rate samples, zero-stuffs them
// into the FIR at one sample per L-cycle frame and tags the FIR output.
module interp_x4_seq
  import interp_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int L          = L_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int FIR_LAT    = 1,
  parameter int FLUSH_LEN  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DW-1:0]        s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DW-1:0]        fir_din,
  input  logic [DW-1:0]        fir_dout,
  output logic [DW-1:0]        m_data,
  output logic                 m_valid,
  output logic [$clog2(L)-1:0] m_phase,
  output logic                 busy,
  output logic                 underrun,
  input  logic                 clr_underrun,
  output state_t               dbg_state
);

  localparam int PW  = $clog2(L);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int FCW = $clog2(FLUSH_LEN + 1);

  state_t          state;
  logic [PW-1:0]   phase;
  logic            stop_pend;
  logic [FCW-1:0]  flush_cnt;
  logic            fifo_pop;
  logic [DW-1:0]   fifo_dout;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic            underrun_set;
  logic            last_phase;
  logic [PW-1:0]   phase_next;
  logic [FIR_LAT:0] vld_pipe;
  logic [PW-1:0]   ph_pipe [FIR_LAT+1];

  // Input handshake: a sample transfers on a rising clk edge where
  // s_valid && s_ready; s_ready depends only on the FIFO fill level.
  assign s_ready      = !fifo_full;
  assign busy         = (state != IDLE);
  assign dbg_state    = state;
  assign last_phase   = (phase == PW'(L - 1));
  assign phase_next   = last_phase ? '0 : phase + 1'b1;
  assign fifo_pop     = (state == RUN) && (phase == '0) && !fifo_empty;
  assign underrun_set = (state == RUN) && (phase == '0) && fifo_empty;

  sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .pop   (fifo_pop),
    .din   (s_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= '0;
      stop_pend <= 1'b0;
      flush_cnt <= '0;
      fir_din   <= '0;
    end else begin
      fir_din <= '0;
      case (state)
        IDLE: begin
          phase     <= '0;
          // start+stop together: start wins, stop is replayed in PRIME
          stop_pend <= start && stop;
          if (start) state <= PRIME;
        end
        PRIME: begin
          if (stop || stop_pend) begin
            state     <= FLUSH;
            stop_pend <= 1'b0;
            flush_cnt <= '0;
          end else if (fifo_count != '0) begin
            state <= RUN;
            phase <= '0;
          end
        end
        RUN: begin
          phase <= phase_next;
          if (phase == '0 && !fifo_empty) fir_din <= fifo_dout;
          if (last_phase) begin
            if (stop || stop_pend) begin
              state     <= FLUSH;
              stop_pend <= 1'b0;
              flush_cnt <= '0;
            end
          end else begin
            stop_pend <= stop_pend | stop;
          end
        end
        FLUSH: begin
          if (flush_cnt == FCW'(FLUSH_LEN - 1)) begin
            state <= IDLE;
            phase <= '0;
          end else begin
            phase     <= phase_next;
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag line: stage 0 lines up with fir_din, the output register adds one more.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int k = 0; k <= FIR_LAT; k++) ph_pipe[k] <= '0;
      m_valid  <= 1'b0;
      m_phase  <= '0;
      m_data   <= '0;
    end else begin
      vld_pipe[0] <= (state == RUN) || (state == FLUSH);
      ph_pipe[0]  <= phase;
      for (int k = 1; k <= FIR_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        ph_pipe[k]  <= ph_pipe[k-1];
      end
      m_valid <= vld_pipe[FIR_LAT];
      m_phase <= ph_pipe[FIR_LAT];
      m_data  <= fir_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            underrun <= 1'b0;
    else if (underrun_set) underrun <= 1'b1;
    else if (clr_underrun) underrun <= 1'b0;
  end

endmodule
